if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/riscv_pkg.sv | 12 +
 rtl/if_id_buffer.sv | 94 +++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants and the fetch-packet type handed from IF to ID.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID two-entry skid buffer: decode outputs come straight from OUT, and
// fetch ready is a registered "SKID is empty" flag.
module if_id_buffer #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [31:0]     i_if_instr,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  output logic [XLEN-1:0] o_id_pc,
  output logic [31:0]     o_id_instr,
  output logic            o_id_valid,
  input  logic            i_id_ready
);

  // The packet type is fixed to the core-wide XLEN.
  if (XLEN != riscv_pkg::XLEN) begin : g_xlen_chk
    $error("if_id_buffer: XLEN must match riscv_pkg::XLEN");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t           state_q, state_d;
  riscv_pkg::fetch_pkt_t out_q, out_d;
  riscv_pkg::fetch_pkt_t skid_q, skid_d;
  riscv_pkg::fetch_pkt_t in_pkt;
  logic                 ready_q;
  logic                 accept, consume;

  assign in_pkt  = '{pc: i_if_pc, instr: i_if_instr};
  assign accept  = i_if_valid & ready_q;
  assign consume = o_id_valid & i_id_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = in_pkt;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          out_d = in_pkt;
        end else if (accept) begin
          skid_d  = in_pkt;
          state_d = TWO;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins; a consume this cycle has already been taken by decode.
    if (i_flush) state_d = EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != TWO);
    end
  end

  assign o_if_ready = ready_q;
  assign o_id_valid = (state_q != EMPTY);
  assign o_id_pc    = out_q.pc;
  assign o_id_instr = o_id_valid ? out_q.instr : NOP_INSTR;

endmodule
